// File: rtl/controle_iluminacao_pkg.sv
// Shared occupancy definitions: FSM state codes and a counter-width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package controle_iluminacao_pkg;

    // State codes are also what appears on the estado output.
    typedef enum logic [1:0] {
        EST_LIVRE   = 2'b00,
        EST_OCUPADO = 2'b01,
        EST_ESPERA  = 2'b10
    } estado_t;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/controle_iluminacao_debounce_sync.sv
// Two-flop synchroniser followed by a level debouncer on the presence flag.
// Latency: a stable change reaches dout on the (DEB_CYCLES+2)th rising edge after it.
// Backpressure: none; pulses shorter than DEB_CYCLES cycles after sync are discarded.
module controle_iluminacao_debounce_sync
    import controle_iluminacao_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int            CW       = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync_q;
    logic          pres_q, pres_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive cycles of disagreement; accept the new level once it has held long enough.
    always_comb begin
        pres_d = pres_q;
        cnt_d  = '0;
        if (sync_q != pres_q) begin
            if (cnt_q == CNT_LAST) begin
                pres_d = sync_q;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Synchroniser chain plus debounce state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
            pres_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync_q  <= sync1_q;
            pres_q  <= pres_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = pres_q;

endmodule

// File: rtl/controle_iluminacao.sv
// Room light controller: debounced presence drives an occupancy FSM with off-delay and event count.
// Latency: input change to estado/luz is DEB_CYCLES+3 edges; off-delay TIMEOUT_TICKS*TICK_DIV cycles.
// Backpressure: none; the block free-runs and limpar_eventos is accepted on any cycle.
module controle_iluminacao
    import controle_iluminacao_pkg::*;
#(
    parameter  int DEB_CYCLES    = 16,
    parameter  int TICK_DIV      = 50_000_000,
    parameter  int TIMEOUT_TICKS = 300,
    parameter  int CNT_W         = 16,
    localparam int TW            = $clog2(TIMEOUT_TICKS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ocupado_in,
    input  logic             limpar_eventos,
    output logic             luz,
    output logic [1:0]       estado,
    output logic [TW-1:0]    tempo_restante,
    output logic [CNT_W-1:0] eventos
);

    localparam int            PW         = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TIMER_INIT = TW'(TIMEOUT_TICKS);

    logic                pres;
    logic                tick;
    logic                inc;
    estado_t             state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [CNT_W-1:0]    eventos_q, eventos_d;

    controle_iluminacao_debounce_sync #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ocupado_in),
        .dout  (pres)
    );

    assign tick = (presc_q == PRESC_LAST);

    // Next state, off-delay timer and prescaler; prescaler only advances while waiting to switch off.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        presc_d = '0;
        inc     = 1'b0;
        case (state_q)
            EST_LIVRE: begin
                timer_d = '0;
                if (pres) begin
                    state_d = EST_OCUPADO;
                    inc     = 1'b1;
                end
            end
            EST_OCUPADO: begin
                timer_d = '0;
                if (!pres) begin
                    state_d = EST_ESPERA;
                    timer_d = TIMER_INIT;
                end
            end
            EST_ESPERA: begin
                if (pres) begin
                    // Re-entry: presence wins even against the final tick, and is not a new event.
                    state_d = EST_OCUPADO;
                    timer_d = '0;
                end else begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        if (timer_q == TW'(1)) begin
                            state_d = EST_LIVRE;
                            timer_d = '0;
                        end else begin
                            timer_d = timer_q - TW'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = EST_LIVRE;
                timer_d = '0;
            end
        endcase
    end

    // Saturating event counter; a clear in the same cycle as an increment wins.
    always_comb begin
        eventos_d = eventos_q;
        if (limpar_eventos) begin
            eventos_d = '0;
        end else if (inc && (eventos_q != {CNT_W{1'b1}})) begin
            eventos_d = eventos_q + CNT_W'(1);
        end
    end

    // All controller state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EST_LIVRE;
            timer_q   <= '0;
            presc_q   <= '0;
            eventos_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            presc_q   <= presc_d;
            eventos_q <= eventos_d;
        end
    end

    assign estado         = state_q;
    assign luz            = (state_q != EST_LIVRE);
    assign tempo_restante = timer_q;
    assign eventos        = eventos_q;

endmodule

// File: tb/tb_controle_iluminacao.sv
// Directed bench for the light controller with small timing parameters.
// Latency: n/a.
// Backpressure: n/a.
module tb_controle_iluminacao;

    localparam int DEB  = 4;
    localparam int DIV  = 4;
    localparam int TMO  = 3;
    localparam int CW   = 2;
    localparam int TW   = $clog2(TMO + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ocupado_in;
    logic          limpar_eventos;
    logic          luz;
    logic [1:0]    estado;
    logic [TW-1:0] tempo_restante;
    logic [CW-1:0] eventos;

    int n_checks = 0;
    int n_errors = 0;

    controle_iluminacao #(
        .DEB_CYCLES    (DEB),
        .TICK_DIV      (DIV),
        .TIMEOUT_TICKS (TMO),
        .CNT_W         (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ocupado_in     (ocupado_in),
        .limpar_eventos (limpar_eventos),
        .luz            (luz),
        .estado         (estado),
        .tempo_restante (tempo_restante),
        .eventos        (eventos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int st, input int l, input int t, input int ev);
        chk({tag, ".estado"}, int'(estado), st);
        chk({tag, ".luz"}, int'(luz), l);
        chk({tag, ".tempo"}, int'(tempo_restante), t);
        chk({tag, ".eventos"}, int'(eventos), ev);
    endtask

    // From OCUPADO: drop presence, wait out the full off-delay to LIVRE, raise again to OCUPADO.
    task automatic full_cycle(input string tag, input int ev_after);
        ocupado_in = 1'b0;
        step(7);
        chk({tag, ".espera"}, int'(estado), 2);
        step(12);
        chk({tag, ".livre"}, int'(estado), 0);
        ocupado_in = 1'b1;
        step(7);
        chk_all({tag, ".ocup"}, 1, 1, 0, ev_after);
    endtask

    initial begin
        rst_n          = 1'b0;
        ocupado_in     = 1'b0;
        limpar_eventos = 1'b0;

        // 1: reset
        #3;
        chk_all("rst_during", 0, 0, 0, 0);
        #7;
        rst_n = 1'b1;
        #1;
        chk_all("rst_after", 0, 0, 0, 0);
        step(1);

        // 3: three-cycle glitch is rejected
        ocupado_in = 1'b1;
        step(3);
        ocupado_in = 1'b0;
        step(15);
        chk_all("glitch", 0, 0, 0, 0);

        // 2: rising presence reaches the FSM on exactly the 7th edge
        ocupado_in = 1'b1;
        step(6);
        chk("rise_edge6.estado", int'(estado), 0);
        step(1);
        chk_all("rise_edge7", 1, 1, 0, 1);

        // 4: drop presence, off-delay countdown to LIVRE
        ocupado_in = 1'b0;
        step(6);
        chk("drop_edge6.estado", int'(estado), 1);
        step(1);
        chk_all("espera_e0", 2, 1, 3, 1);
        step(3);
        chk("espera_e3.tempo", int'(tempo_restante), 3);
        step(1);
        chk("espera_e4.tempo", int'(tempo_restante), 2);
        step(4);
        chk("espera_e8.tempo", int'(tempo_restante), 1);
        step(3);
        chk("espera_e11.estado", int'(estado), 2);
        step(1);
        chk_all("espera_e12", 0, 0, 0, 1);

        // 5: re-entry with presence landing on the final tick
        ocupado_in = 1'b1;
        step(7);
        chk_all("reocup", 1, 1, 0, 2);
        ocupado_in = 1'b0;
        step(7);
        chk_all("re_e0", 2, 1, 3, 2);
        step(5);
        chk("re_e5.tempo", int'(tempo_restante), 2);
        ocupado_in = 1'b1;
        for (int i = 6; i <= 11; i++) begin
            step(1);
            chk($sformatf("re_e%0d.luz", i), int'(luz), 1);
        end
        chk("re_e11.tempo", int'(tempo_restante), 1);
        step(1);
        chk_all("re_e12", 1, 1, 0, 2);

        // 6: saturation at 3
        full_cycle("sat3", 3);
        full_cycle("sat_hold", 3);

        // clear alone leaves the FSM untouched
        limpar_eventos = 1'b1;
        step(1);
        limpar_eventos = 1'b0;
        chk_all("clr_alone", 1, 1, 0, 0);

        // clear coincident with an increment
        ocupado_in = 1'b0;
        step(19);
        chk("clr_inc.livre", int'(estado), 0);
        ocupado_in = 1'b1;
        step(6);
        limpar_eventos = 1'b1;
        step(1);
        limpar_eventos = 1'b0;
        chk_all("clr_inc", 1, 1, 0, 0);
        full_cycle("after_clr", 1);

        // async reset mid-ESPERA takes effect before the next edge
        ocupado_in = 1'b0;
        step(7);
        chk_all("pre_arst", 2, 1, 3, 1);
        step(2);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all("arst_now", 0, 0, 0, 0);
        step(2);
        rst_n = 1'b1;
        step(2);
        chk_all("arst_after", 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
